// File: rtl/hilo_acc.sv
// hilo_acc -- HI/LO special-register unit with a two-cycle multiply-accumulate path.
//
// Holds the architectural HI and LO registers next to the writeback stage.
// It supports independent HI/LO writes (MTHI/MTLO), a combined write, a clear,
// and MADD/MSUB. MADD/MSUB add a 2*DATA_W product to {HI,LO} or subtract it.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       asynchronous active-low reset (release is synchronised upstream)
//   op_valid  an operation is presented this cycle
//   op_ready  the unit can accept an operation this cycle (= !busy_o)
//   op        000 NOP, 001 WHI, 010 WLO, 011 WBOTH, 100 MADD, 101 MSUB,
//             110 CLR, 111 reserved (NOP)
//   hi_i      HI write value / upper half of the product
//   lo_i      LO write value / lower half of the product
//   flush     cancels a pending accumulate and any op presented this cycle
//   hi_o      architectural HI
//   lo_o      architectural LO
//   busy_o    accumulate in flight (stage 1 holds an operand); mirrors the FSM state
//   carry_o   sticky carry/borrow out of the 2*DATA_W accumulate
//
// Handshake: an op transfers on a rising edge where op_valid && op_ready && !flush.
// The producer holds op/hi_i/lo_i stable while op_valid is high and op_ready is low.
// op_ready depends only on the registered busy flag. It never depends on op_valid.
module hilo_acc #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              flush,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              busy_o,
    output logic              carry_o
);

    localparam int ACC_W = 2 * DATA_W;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_WHI   = 3'b001;
    localparam logic [2:0] OP_WLO   = 3'b010;
    localparam logic [2:0] OP_WBOTH = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_CLR   = 3'b110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] operand;
    logic             sub_q;
    logic             accept;
    logic [ACC_W:0]   ext_res;

    assign op_ready = ~busy_o;
    assign accept   = op_valid & op_ready & ~flush;

    // Zero-extended by one bit. For an add, the top bit is the carry-out.
    // For a subtract, it is the borrow: it is set exactly when {hi,lo} < operand.
    always_comb begin
        ext_res = '0;
        if (sub_q) begin
            ext_res = {1'b0, hi_o, lo_o} - {1'b0, operand};
        end else begin
            ext_res = {1'b0, hi_o, lo_o} + {1'b0, operand};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            busy_o  <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
            carry_o <= 1'b0;
            operand <= '0;
            sub_q   <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    // Stage 2. op_ready is low here, so nothing else can write HI/LO.
                    // A flush drops the result and leaves HI, LO and carry untouched.
                    if (!flush) begin
                        hi_o    <= ext_res[ACC_W-1:DATA_W];
                        lo_o    <= ext_res[DATA_W-1:0];
                        carry_o <= carry_o | ext_res[ACC_W];
                    end
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    if (accept) begin
                        case (op)
                            OP_WHI: hi_o <= hi_i;
                            OP_WLO: lo_o <= lo_i;
                            OP_WBOTH: begin
                                hi_o    <= hi_i;
                                lo_o    <= lo_i;
                                carry_o <= 1'b0;
                            end
                            OP_CLR: begin
                                hi_o    <= '0;
                                lo_o    <= '0;
                                carry_o <= 1'b0;
                            end
                            OP_MADD, OP_MSUB: begin
                                operand <= {hi_i, lo_i};
                                sub_q   <= (op == OP_MSUB);
                                state   <= ST_ACC;
                                busy_o  <= 1'b1;
                            end
                            OP_NOP:  ;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_acc.sv
module tb_hilo_acc;

  localparam int DATA_W = 32;

  localparam logic [2:0] NOP   = 3'b000;
  localparam logic [2:0] WHI   = 3'b001;
  localparam logic [2:0] WLO   = 3'b010;
  localparam logic [2:0] WBOTH = 3'b011;
  localparam logic [2:0] MADD  = 3'b100;
  localparam logic [2:0] MSUB  = 3'b101;
  localparam logic [2:0] CLR   = 3'b110;
  localparam logic [2:0] RSVD  = 3'b111;

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              rst;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              flush;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              busy_o;
  logic              carry_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hilo_acc #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .hi_i     (hi_i),
    .lo_i     (lo_i),
    .flush    (flush),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy_o   (busy_o),
    .carry_o  (carry_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo,
                           input logic e_c, input logic e_b);
    check({tag, " hi"}, 64'(hi_o), 64'(e_hi));
    check({tag, " lo"}, 64'(lo_o), 64'(e_lo));
    check({tag, " carry"}, 64'(carry_o), 64'(e_c));
    check({tag, " busy"}, 64'(busy_o), 64'(e_b));
    check({tag, " ready"}, 64'(op_ready), 64'(!e_b));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] h,
                       input logic [31:0] l, input logic f);
    op_valid = v;
    op       = o;
    hi_i     = h;
    lo_i     = l;
    flush    = f;
  endtask

  // advance one edge; outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [2:0]  o;
    logic [31:0] h;
    logic [31:0] l;
    logic        f;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_c;
    logic        e_b;
  } vec_t;

  vec_t vecs[$];

  // ---------------- reference model (64-bit arithmetic) ----------------
  logic [63:0] m_acc;
  logic [63:0] m_opnd;
  logic        m_carry;
  logic        m_busy;
  logic        m_sub;
  logic [65:0] exp_q[$];

  task automatic model_cycle(input logic v, input logic [2:0] o, input logic [31:0] h,
                             input logic [31:0] l, input logic f);
    logic [63:0] nv;
    if (m_busy) begin
      if (!f) begin
        if (m_sub) begin
          nv = m_acc - m_opnd;
          if (m_acc < m_opnd) m_carry = 1'b1;
        end else begin
          nv = m_acc + m_opnd;
          if (nv < m_acc) m_carry = 1'b1;
        end
        m_acc = nv;
      end
      m_busy = 1'b0;
    end else if (v && !f) begin
      case (o)
        WHI:   m_acc[63:32] = h;
        WLO:   m_acc[31:0]  = l;
        WBOTH: begin m_acc = {h, l}; m_carry = 1'b0; end
        CLR:   begin m_acc = '0; m_carry = 1'b0; end
        MADD, MSUB: begin m_opnd = {h, l}; m_sub = (o == MSUB); m_busy = 1'b1; end
        default: ;
      endcase
    end
    exp_q.push_back({m_carry, m_busy, m_acc});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [65:0] e;
    rst = 1'b0;
    drive(0, NOP, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;

    // Reset mid-accumulate
    drive(1, WBOTH, 32'h1111_1111, 32'h2222_2222, 0); step();
    drive(1, MADD, 32'h0, 32'h5, 0); step();
    check_all("pre-rst acc", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1);
    drive(0, NOP, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    check_all("rst mid-acc", 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    step();
    check_all("after rst", 32'h0, 32'h0, 1'b0, 1'b0);

    // table: {v, op, hi, lo, flush, exp_hi, exp_lo, exp_c, exp_busy}
    vecs.push_back('{1, WBOTH, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0});
    vecs.push_back('{1, WBOTH, 32'h1, 32'h2, 0, 32'h1, 32'h2, 0, 0});
    vecs.push_back('{1, WHI, 32'hAAAA_0000, 32'hDEAD, 0, 32'hAAAA_0000, 32'h2, 0, 0});
    vecs.push_back('{1, WLO, 32'hBEEF, 32'h0000_BBBB, 0, 32'hAAAA_0000, 32'h0000_BBBB, 0, 0});
    vecs.push_back('{1, WBOTH, 32'h0, 32'hFFFF_FFFF, 0, 32'h0, 32'hFFFF_FFFF, 0, 0});
    vecs.push_back('{1, MADD, 32'h0, 32'h1, 0, 32'h0, 32'hFFFF_FFFF, 0, 1});
    vecs.push_back('{0, NOP, 32'h0, 32'h0, 0, 32'h1, 32'h0, 0, 0});
    vecs.push_back('{1, WBOTH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0});
    vecs.push_back('{1, MADD, 32'h0, 32'h1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1});
    vecs.push_back('{0, NOP, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1, 0});
    vecs.push_back('{1, MSUB, 32'h0, 32'h1, 0, 32'h0, 32'h0, 1, 1});
    vecs.push_back('{0, NOP, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0});
    vecs.push_back('{1, WHI, 32'h0, 32'h0, 0, 32'h0, 32'hFFFF_FFFF, 1, 0});
    vecs.push_back('{1, CLR, 32'h5, 32'h5, 0, 32'h0, 32'h0, 0, 0});
    vecs.push_back('{1, WBOTH, 32'h5, 32'h6, 0, 32'h5, 32'h6, 0, 0});
    vecs.push_back('{1, MADD, 32'h1, 32'h1, 0, 32'h5, 32'h6, 0, 1});
    vecs.push_back('{0, NOP, 32'h0, 32'h0, 1, 32'h5, 32'h6, 0, 0});
    vecs.push_back('{1, WHI, 32'h77, 32'h0, 1, 32'h5, 32'h6, 0, 0});
    vecs.push_back('{0, WHI, 32'h88, 32'h0, 0, 32'h5, 32'h6, 0, 0});
    vecs.push_back('{1, RSVD, 32'h99, 32'h99, 0, 32'h5, 32'h6, 0, 0});
    vecs.push_back('{1, NOP, 32'h99, 32'h99, 0, 32'h5, 32'h6, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].o, vecs[i].h, vecs[i].l, vecs[i].f);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_c, vecs[i].e_b);
    end

    // Stall handshake: WLO held valid while the MADD is in stage 1
    drive(1, WBOTH, 32'h0, 32'h10, 0); step();
    drive(1, MADD, 32'h0, 32'h5, 0); step();                   // cycle N+1
    drive(1, WLO, 32'h0, 32'h55, 0);
    check_all("stall N+1", 32'h0, 32'h10, 1'b0, 1'b1);
    step();                                                    // cycle N+2
    check_all("stall N+2", 32'h0, 32'h15, 1'b0, 1'b0);
    step();                                                    // cycle N+3
    drive(0, NOP, 0, 0, 0);
    check_all("stall N+3", 32'h0, 32'h55, 1'b0, 1'b0);

    // Random stimulus against the model
    drive(1, CLR, 0, 0, 0); step();
    check_all("rand sync", 32'h0, 32'h0, 1'b0, 1'b0);
    m_acc = '0; m_opnd = '0; m_carry = 1'b0; m_busy = 1'b0; m_sub = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic [2:0]  o;
      logic [31:0] h;
      logic [31:0] l;
      logic        f;
      v = ($urandom_range(0, 3) != 0);
      o = 3'($urandom_range(0, 7));
      h = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      l = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      f = ($urandom_range(0, 9) == 0);
      drive(v, o, h, l, f);
      model_cycle(v, o, h, l, f);
      step();
      e = exp_q.pop_front();
      check($sformatf("rand%0d acc", i), {hi_o, lo_o}, e[63:0]);
      check($sformatf("rand%0d busy", i), 64'(busy_o), 64'(e[64]));
      check($sformatf("rand%0d carry", i), 64'(carry_o), 64'(e[65]));
    end
    drive(0, NOP, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_acc.md
# hilo_acc

Parametrised HI/LO special-register unit for the flowCPU_mips pipeline, sitting beside the writeback stage. Supersedes the single-write-enable HI/LO register: independent HI and LO writes (MTHI/MTLO), a clear, and a two-cycle 2·DATA_W accumulate path for MADD/MSUB with a valid/ready handshake, a flush for exceptions, and a sticky carry flag.

## Interface
- DATA_W, 32, width of HI and LO each; the accumulator is 2·DATA_W wide
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- op_valid  in  1  an operation is presented this cycle
- op_ready  out  1  the unit can accept an operation this cycle
- op  in  3  000 NOP, 001 WHI, 010 WLO, 011 WBOTH, 100 MADD, 101 MSUB, 110 CLR, 111 reserved (treated as NOP)
- hi_i  in  DATA_W  HI operand: the write value, or the upper half of the product
- lo_i  in  DATA_W  LO operand: the write value, or the lower half of the product
- flush  in  1  cancels the pending accumulate and any operation presented this cycle
- hi_o  out  DATA_W  architectural HI
- lo_o  out  DATA_W  architectural LO
- busy_o  out  1  an accumulate is in flight in stage 1
- carry_o  out  1  sticky carry/borrow out of the 2·DATA_W accumulate

## Operation
- Acceptance: an operation is accepted when op_valid & op_ready & !flush. An operation that is not accepted has no effect.
- op_ready is !busy_o.
- WHI: hi_o <= hi_i; LO holds.
- WLO: lo_o <= lo_i; HI holds.
- WBOTH: hi_o <= hi_i, lo_o <= lo_i; carry_o <= 0.
- CLR: hi_o, lo_o, carry_o <= 0.
- NOP and reserved opcodes: no state change, and no busy cycle.
- MADD / MSUB, stage 1:
  - on acceptance, latch {hi_i,lo_i} into a 2·DATA_W operand register and latch the direction (add/sub);
  - set busy_o.
- MADD / MSUB, stage 2 (the next cycle):
  - S = {hi_o,lo_o} + operand (MADD) or {hi_o,lo_o} − operand (MSUB), computed modulo 2^(2·DATA_W);
  - {hi_o,lo_o} <= S;
  - carry_o <= carry_o | carry-out (MADD) or carry_o | borrow (MSUB);
  - clear busy_o.
- The arithmetic is sign-agnostic. The signed/unsigned product is formed upstream, and the HI/LO bit pattern is identical either way.
- Flush:
  - when busy_o is set, clear busy_o on the edge; HI, LO and carry_o are not updated;
  - any operation presented in the same cycle is discarded;
  - when nothing is pending, flush only blocks that cycle's acceptance.
- Reset, asserted at any time including mid-accumulate:
  - hi_o = 0, lo_o = 0, carry_o = 0, busy_o = 0, op_ready = 1;
  - the operand register is cleared;
  - the pending accumulate is lost.

## Timing
- Write ops (WHI, WLO, WBOTH, CLR) accepted in cycle N are visible on hi_o/lo_o in cycle N+1.
- An accumulate accepted in cycle N:
  - busy_o = 1 and op_ready = 0 in cycle N+1;
  - the result is visible in cycle N+2;
  - the next operation can be accepted in cycle N+2.
- Back-to-back accumulates run one every 2 cycles.
- hi_o, lo_o, busy_o and carry_o are registered outputs. op_ready is combinational from busy_o only.
- op_valid while busy_o is set: the operation is held off. The producer keeps op/hi_i/lo_i stable until op_ready.
- Stage 2 reads hi_o/lo_o from cycle N+1. No write can slip in between stage 1 and stage 2, because op_ready is low.
- rst deassertion must be synchronous to clk; it is released through a 2-flop synchroniser outside this block.

## Test plan
- Reset then write:
  - with rst low mid-accumulate, all outputs are 0 and op_ready = 1;
  - after release, WBOTH hi_i=0x12345678 lo_i=0x9ABCDEF0 -> the next cycle hi_o=0x12345678, lo_o=0x9ABCDEF0.
- Split writes: from HI=0x1, LO=0x2, WHI 0xAAAA0000 then WLO 0x0000BBBB -> HI=0xAAAA0000, LO=0x0000BBBB, each visible 1 cycle after acceptance, and the other half unchanged.
- MADD low-to-high carry: HI=0, LO=0xFFFFFFFF, MADD {0,1} -> cycle N+1 busy_o=1, op_ready=0; cycle N+2 HI=0x00000001, LO=0, carry_o=0.
- MADD/MSUB wrap:
  - HI=LO=0xFFFFFFFF, MADD {0,1} -> HI=LO=0, carry_o=1;
  - then MSUB {0,1} -> HI=LO=0xFFFFFFFF, carry_o stays 1;
  - then CLR -> all 0.
- Flush:
  - MADD accepted, flush asserted the next cycle -> HI/LO/carry unchanged, busy_o=0 the cycle after;
  - a WHI presented together with flush -> ignored.
- Stall handshake:
  - MADD in cycle N, then WLO 0x55 held valid from cycle N+1 -> WLO accepted only in cycle N+2;
  - LO reflects the MADD result in N+2 and is 0x55 in N+3.
